// File: rtl/fetch_sequencer_if.sv
// -----------------------------------------------------------------------------
// fetch_sequencer_if
// Bundles the fetch sequencer's execute, instruction-memory and decode
// signals into one interface.
//
// Handshake semantics:
//   - Request and decode channels are valid/ready. A transfer happens on a
//     rising clock edge where valid && ready.
//   - Once the sequencer raises dec_valid, it holds dec_valid, dec_instr and
//     dec_pc stable until the transfer completes. A redirect may still
//     withdraw them.
//   - The response channel is valid-only. Exactly one response word arrives
//     for each accepted request.
//
// Modports:
//   master - the fetch sequencer.
//   slave  - its environment: execute, instruction memory and decode.
// -----------------------------------------------------------------------------
interface fetch_sequencer_if #(
    parameter int unsigned ADDR_WIDTH  = 32,
    parameter int unsigned INSTR_WIDTH = 32
) ();
    logic                   redirect_valid;
    logic [ADDR_WIDTH-1:0]  redirect_target;
    logic                   imem_req_valid;
    logic                   imem_req_ready;
    logic [ADDR_WIDTH-1:0]  imem_req_addr;
    logic                   imem_rsp_valid;
    logic [INSTR_WIDTH-1:0] imem_rsp_data;
    logic                   dec_valid;
    logic                   dec_ready;
    logic [INSTR_WIDTH-1:0] dec_instr;
    logic [ADDR_WIDTH-1:0]  dec_pc;

    modport master (
        input  redirect_valid, redirect_target,
        output imem_req_valid, imem_req_addr,
        input  imem_req_ready,
        input  imem_rsp_valid, imem_rsp_data,
        output dec_valid, dec_instr, dec_pc,
        input  dec_ready
    );

    modport slave (
        output redirect_valid, redirect_target,
        input  imem_req_valid, imem_req_addr,
        output imem_req_ready,
        output imem_rsp_valid, imem_rsp_data,
        input  dec_valid, dec_instr, dec_pc,
        output dec_ready
    );
endinterface

// File: rtl/fetch_sequencer.sv
// -----------------------------------------------------------------------------
// fetch_sequencer
// Owns the RV32I fetch PC. It keeps at most one request outstanding to
// instruction memory. Returned words are buffered in an output register plus
// a skid entry on their way to decode. Redirects from execute discard every
// buffered word and any fetch still in flight.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous reset, active-low (0 = reset)
//   bus        fetch_sequencer_if.master, which carries:
//                - redirect_valid / redirect_target
//                - imem_req_*  (valid/ready)
//                - imem_rsp_*  (valid-only)
//                - dec_*       (valid/ready)
//   dbg_state  current FSM state (0 IDLE, 1 REQ, 2 WAIT, 3 DROP)
// -----------------------------------------------------------------------------
module fetch_sequencer #(
    parameter int unsigned           ADDR_WIDTH   = 32,
    parameter int unsigned           INSTR_WIDTH  = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = '0
) (
    input  logic              clk,
    input  logic              rst,
    fetch_sequencer_if.master bus,
    output logic [1:0]        dbg_state
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_DROP = 2'd3
    } state_t;

    state_t                 state_q, state_d;
    logic [ADDR_WIDTH-1:0]  pc_q, pc_d;
    logic [ADDR_WIDTH-1:0]  req_pc_q, req_pc_d;
    logic                   out_valid_q, out_valid_d;
    logic [INSTR_WIDTH-1:0] out_instr_q, out_instr_d;
    logic [ADDR_WIDTH-1:0]  out_pc_q, out_pc_d;
    logic                   skid_valid_q, skid_valid_d;
    logic [INSTR_WIDTH-1:0] skid_instr_q, skid_instr_d;
    logic [ADDR_WIDTH-1:0]  skid_pc_q, skid_pc_d;

    logic                   redirect_act;
    logic                   req_valid;
    logic                   req_fire;
    logic                   dec_fire;
    logic                   rsp_accept;
    logic [ADDR_WIDTH-1:0]  target_aligned;

    // The low two bits of the target are dropped: fetch is word-aligned.
    assign target_aligned = bus.redirect_target & ~ADDR_WIDTH'(3);

    // Redirects are only meaningful once the sequencer has left IDLE.
    assign redirect_act = bus.redirect_valid && (state_q != S_IDLE);

    // A new fetch only needs a guaranteed landing slot for its word. While
    // the skid is empty one always exists: the word goes into either the
    // output register or the skid. So the skid can never be overwritten.
    assign req_valid  = (state_q == S_REQ) && !bus.redirect_valid && !skid_valid_q;
    assign req_fire   = req_valid && bus.imem_req_ready;
    assign dec_fire   = out_valid_q && bus.dec_ready;
    assign rsp_accept = (state_q == S_WAIT) && bus.imem_rsp_valid && !bus.redirect_valid;

    assign bus.imem_req_valid = req_valid;
    assign bus.imem_req_addr  = pc_q;
    assign bus.dec_valid      = out_valid_q;
    assign bus.dec_instr      = out_instr_q;
    assign bus.dec_pc         = out_pc_q;
    assign dbg_state          = state_q;

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        req_pc_d     = req_pc_q;
        out_valid_d  = out_valid_q;
        out_instr_d  = out_instr_q;
        out_pc_d     = out_pc_q;
        skid_valid_d = skid_valid_q;
        skid_instr_d = skid_instr_q;
        skid_pc_d    = skid_pc_q;

        // Decode side: a consumed head is replaced by the skid word, if any.
        if (dec_fire) begin
            if (skid_valid_q) begin
                out_valid_d  = 1'b1;
                out_instr_d  = skid_instr_q;
                out_pc_d     = skid_pc_q;
                skid_valid_d = 1'b0;
            end else begin
                out_valid_d = 1'b0;
            end
        end

        // Memory side: the word lands in the output register if that is free
        // after this cycle's drain. Otherwise it waits in the skid.
        if (rsp_accept) begin
            if (!out_valid_d) begin
                out_valid_d = 1'b1;
                out_instr_d = bus.imem_rsp_data;
                out_pc_d    = req_pc_q;
            end else begin
                skid_valid_d = 1'b1;
                skid_instr_d = bus.imem_rsp_data;
                skid_pc_d    = req_pc_q;
            end
        end

        case (state_q)
            S_IDLE: state_d = S_REQ;
            S_REQ: begin
                if (req_fire) begin
                    req_pc_d = pc_q;
                    pc_d     = pc_q + ADDR_WIDTH'(4);
                    state_d  = S_WAIT;
                end
            end
            S_WAIT: begin
                // If a redirect arrives together with the response, the word
                // is discarded but nothing remains outstanding.
                if (bus.imem_rsp_valid) begin
                    state_d = S_REQ;
                end else if (bus.redirect_valid) begin
                    state_d = S_DROP;
                end
            end
            S_DROP: begin
                // The response being dropped retires the outstanding fetch,
                // even if a further redirect arrives in the same cycle.
                if (bus.imem_rsp_valid) begin
                    state_d = S_REQ;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // A redirect overrides everything else. It reloads the PC and empties
        // the buffer. A decode transfer in the same cycle has already
        // completed.
        if (redirect_act) begin
            pc_d         = target_aligned;
            out_valid_d  = 1'b0;
            skid_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            pc_q         <= RESET_VECTOR;
            req_pc_q     <= '0;
            out_valid_q  <= 1'b0;
            out_instr_q  <= '0;
            out_pc_q     <= '0;
            skid_valid_q <= 1'b0;
            skid_instr_q <= '0;
            skid_pc_q    <= '0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            req_pc_q     <= req_pc_d;
            out_valid_q  <= out_valid_d;
            out_instr_q  <= out_instr_d;
            out_pc_q     <= out_pc_d;
            skid_valid_q <= skid_valid_d;
            skid_instr_q <= skid_instr_d;
            skid_pc_q    <= skid_pc_d;
        end
    end
endmodule

// File: tb/tb_fetch_sequencer.sv
// -----------------------------------------------------------------------------
// tb_fetch_sequencer
// Directed and random stimulus for fetch_sequencer. A second instance with a
// top-of-memory reset vector exercises PC wrap-around.
//
// The reference model tracks the program-order stream at the PC level:
//   - the next address to request and the next PC expected at decode;
//   - both jump to a redirect target;
//   - decode words must match a fixed function of their PC.
// A small memory model answers each accepted request once, after a random
// latency.
// -----------------------------------------------------------------------------
module tb_fetch_sequencer;
    localparam int AW = 32;
    localparam int IW = 32;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] dbg_state;
    logic [1:0] w_dbg_state;

    always #5 clk = ~clk;

    fetch_sequencer_if #(.ADDR_WIDTH(AW), .INSTR_WIDTH(IW)) bus ();
    fetch_sequencer_if #(.ADDR_WIDTH(AW), .INSTR_WIDTH(IW)) wbus ();

    fetch_sequencer #(.ADDR_WIDTH(AW), .INSTR_WIDTH(IW), .RESET_VECTOR(32'h0000_0000)) dut (
        .clk(clk), .rst(rst), .bus(bus), .dbg_state(dbg_state)
    );

    fetch_sequencer #(.ADDR_WIDTH(AW), .INSTR_WIDTH(IW), .RESET_VECTOR(32'hFFFF_FFFC)) dut_wrap (
        .clk(clk), .rst(rst), .bus(wbus), .dbg_state(w_dbg_state)
    );

    int checks = 0;
    int errors = 0;

    // memory model
    int          ready_pct;
    int          lat_min;
    int          lat_max;
    bit          pend_valid;
    bit          pend_dropped;
    logic [31:0] pend_addr;
    int          pend_cnt;

    // reference model of the program-order stream
    logic [31:0] exp_req_pc;
    logic [31:0] exp_dec_pc;
    bit          prev_redirect;
    bit          prev_stall;
    bit          prev_dv;
    bit          prev_rsp_kept;
    logic [31:0] prev_pc;
    logic [31:0] prev_instr;
    logic [31:0] prev_rsp_addr;
    int          req_fires;
    int          dec_fires;
    logic [31:0] last_req_addr;
    logic [31:0] dec_log[$];
    int          cyc_since_reset;

    // wrap instance: always-ready memory with one-cycle latency
    bit          w_pend;
    logic [31:0] w_pend_addr;
    logic [31:0] wrap_q[$];
    logic [31:0] wdec_q[$];

    function automatic logic [31:0] word_of(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'hC0DE_0000;
    endfunction

    function automatic logic [31:0] qget(input logic [31:0] q[$], input int i);
        if (i < q.size()) return q[i];
        return 32'hDEAD_BEEF;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b0;
        bus.redirect_valid   = 1'b0;
        bus.redirect_target  = '0;
        bus.dec_ready        = 1'b0;
        bus.imem_req_ready   = 1'b0;
        bus.imem_rsp_valid   = 1'b0;
        bus.imem_rsp_data    = '0;
        wbus.redirect_valid  = 1'b0;
        wbus.redirect_target = '0;
        wbus.dec_ready       = 1'b1;
        wbus.imem_req_ready  = 1'b1;
        wbus.imem_rsp_valid  = 1'b0;
        wbus.imem_rsp_data   = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_dec_valid", bus.dec_valid, 0);
        check("rst_dec_pc", bus.dec_pc, 0);
        check("rst_dec_instr", bus.dec_instr, 0);
        check("rst_req_valid", bus.imem_req_valid, 0);
        check("rst_req_addr", bus.imem_req_addr, 0);
        pend_valid    = 0;
        pend_dropped  = 0;
        pend_cnt      = 0;
        w_pend        = 0;
        exp_req_pc    = 32'h0;
        exp_dec_pc    = 32'h0;
        prev_redirect = 0;
        prev_stall    = 0;
        prev_dv       = 0;
        prev_rsp_kept = 0;
        dec_log.delete();
        wrap_q.delete();
        wdec_q.delete();
        cyc_since_reset = 0;
        rst = 1'b1;
    endtask

    // One clock cycle. It is entered at a falling edge, with the execute and
    // decode inputs already set by the caller.
    task automatic tick();
        bit rsp_now, req_fire, dec_fire, redir, w_rsp_now;
        rsp_now = pend_valid && (pend_cnt == 0);
        bus.imem_rsp_valid = rsp_now;
        bus.imem_rsp_data  = rsp_now ? word_of(pend_addr) : 32'h0;
        bus.imem_req_ready = ($urandom_range(0, 99) < ready_pct);
        w_rsp_now = w_pend;
        wbus.imem_rsp_valid = w_pend;
        wbus.imem_rsp_data  = w_pend ? word_of(w_pend_addr) : 32'h0;
        #1;
        redir    = bus.redirect_valid;
        req_fire = bus.imem_req_valid && bus.imem_req_ready;
        dec_fire = bus.dec_valid && bus.dec_ready;

        if (prev_redirect) begin
            check("flush_dec_valid", bus.dec_valid, 0);
        end else if (prev_stall) begin
            check("stall_valid", bus.dec_valid, 1);
            check("stall_pc", bus.dec_pc, prev_pc);
            check("stall_instr", bus.dec_instr, prev_instr);
        end
        if (prev_rsp_kept) begin
            check("rsp_visible", bus.dec_valid, 1);
            if (!prev_dv) check("rsp_latency_pc", bus.dec_pc, prev_rsp_addr);
        end
        if (redir) check("no_req_on_redirect", bus.imem_req_valid, 0);
        if (req_fire) begin
            check("single_outstanding", pend_valid, 0);
            check("req_addr", bus.imem_req_addr, exp_req_pc);
            exp_req_pc    = exp_req_pc + 32'd4;
            last_req_addr = bus.imem_req_addr;
            req_fires++;
        end
        if (dec_fire) begin
            check("dec_pc", bus.dec_pc, exp_dec_pc);
            check("dec_instr", bus.dec_instr, word_of(exp_dec_pc));
            exp_dec_pc = exp_dec_pc + 32'd4;
            dec_log.push_back(bus.dec_pc);
            dec_fires++;
        end

        prev_redirect = redir;
        prev_stall    = bus.dec_valid && !bus.dec_ready && !redir;
        prev_dv       = bus.dec_valid;
        prev_pc       = bus.dec_pc;
        prev_instr    = bus.dec_instr;
        prev_rsp_kept = rsp_now && !redir && !pend_dropped;
        prev_rsp_addr = pend_addr;
        if (redir) begin
            exp_req_pc = {bus.redirect_target[31:2], 2'b00};
            exp_dec_pc = {bus.redirect_target[31:2], 2'b00};
            if (pend_valid) pend_dropped = 1;
        end
        if (rsp_now) pend_valid = 0;
        else if (pend_valid) pend_cnt--;
        if (req_fire) begin
            pend_valid   = 1;
            pend_dropped = 0;
            pend_addr    = bus.imem_req_addr;
            pend_cnt     = $urandom_range(lat_min, lat_max) - 1;
        end

        if (w_rsp_now) w_pend = 0;
        if (wbus.imem_req_valid) begin
            if (wrap_q.size() < 4) wrap_q.push_back(wbus.imem_req_addr);
            w_pend      = 1;
            w_pend_addr = wbus.imem_req_addr;
        end
        if (wbus.dec_valid && wdec_q.size() < 4) wdec_q.push_back(wbus.dec_pc);

        @(posedge clk);
        @(negedge clk);
        cyc_since_reset++;
    endtask

    task automatic run_until_req(input int budget, output bit ok);
        int start;
        start = req_fires;
        ok = 0;
        for (int i = 0; i < budget; i++) begin
            tick();
            if (req_fires != start) begin
                ok = 1;
                break;
            end
        end
    endtask

    task automatic run_until_dec(input int budget, output bit ok);
        int start;
        start = dec_fires;
        ok = 0;
        for (int i = 0; i < budget; i++) begin
            tick();
            if (dec_fires != start) begin
                ok = 1;
                break;
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "simulation time limit");
    end

    initial begin
        bit ok;
        bit dv_hist[12];
        int r0;
        int d0;

        ready_pct = 100;
        lat_min   = 1;
        lat_max   = 1;
        req_fires = 0;
        dec_fires = 0;
        last_req_addr = '0;

        // 1: reset, one IDLE cycle, then the first request to the reset vector
        do_reset();
        check("t1_idle_no_req", bus.imem_req_valid, 0);
        tick();
        check("t1_req_valid", bus.imem_req_valid, 1);
        check("t1_req_addr", bus.imem_req_addr, 32'h0);

        // 2: zero-wait streaming: dec_valid alternates from cycle 3 onwards
        bus.dec_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            dv_hist[i] = bus.dec_valid;
            tick();
        end
        for (int i = 2; i < 12; i++) check("t2_dv_alternate", 32'(dv_hist[i]), 32'((i % 2) == 0));
        check("t2_count", dec_log.size(), 5);
        check("t2_pc0", qget(dec_log, 0), 32'h0);
        check("t2_pc1", qget(dec_log, 1), 32'h4);
        check("t2_pc2", qget(dec_log, 2), 32'h8);

        // 3: backpressure fills both entries; fetch then resumes at 0x8
        do_reset();
        bus.dec_ready = 1'b0;
        tick();
        r0 = req_fires;
        for (int i = 0; i < 10; i++) tick();
        check("t3_two_reqs", req_fires - r0, 2);
        check("t3_no_third_req", bus.imem_req_valid, 0);
        check("t3_head_pc", bus.dec_pc, 32'h0);
        bus.dec_ready = 1'b1;
        run_until_req(8, ok);
        check("t3_resume_ok", ok, 1);
        check("t3_resume_addr", last_req_addr, 32'h8);
        for (int i = 0; i < 4; i++) tick();
        check("t3_drain0", qget(dec_log, 0), 32'h0);
        check("t3_drain1", qget(dec_log, 1), 32'h4);
        check("t3_drain2", qget(dec_log, 2), 32'h8);

        // 4: redirect while waiting; the late response must be dropped
        do_reset();
        bus.dec_ready = 1'b1;
        lat_min = 4;
        lat_max = 4;
        tick();
        tick();
        lat_min = 1;
        lat_max = 1;
        bus.redirect_valid  = 1'b1;
        bus.redirect_target = 32'h0000_0103;
        tick();
        bus.redirect_valid = 1'b0;
        check("t4_no_req_in_drop", bus.imem_req_valid, 0);
        run_until_req(10, ok);
        check("t4_req_ok", ok, 1);
        check("t4_req_addr", last_req_addr, 32'h100);
        run_until_dec(10, ok);
        check("t4_dec_ok", ok, 1);
        check("t4_first_dec_pc", qget(dec_log, 0), 32'h100);

        // 5: redirect with a response arriving and a stalled head at decode
        do_reset();
        bus.dec_ready = 1'b0;
        r0 = req_fires;
        for (int i = 0; i < 4; i++) tick();
        check("t5_setup_reqs", req_fires - r0, 2);
        check("t5_head_stalled", bus.dec_valid, 1);
        bus.redirect_valid  = 1'b1;
        bus.redirect_target = 32'h0000_0200;
        tick();
        bus.redirect_valid = 1'b0;
        check("t5_flushed", bus.dec_valid, 0);
        bus.dec_ready = 1'b1;
        run_until_req(10, ok);
        check("t5_req_ok", ok, 1);
        check("t5_req_addr", last_req_addr, 32'h200);
        run_until_dec(10, ok);
        check("t5_dec_ok", ok, 1);
        check("t5_first_dec_pc", qget(dec_log, 0), 32'h200);

        // 6: wrap from the top of the address space
        do_reset();
        for (int i = 0; i < 10; i++) tick();
        check("t6_req0", qget(wrap_q, 0), 32'hFFFF_FFFC);
        check("t6_req1", qget(wrap_q, 1), 32'h0000_0000);
        check("t6_dec0", qget(wdec_q, 0), 32'hFFFF_FFFC);

        // 7: random traffic, with a reset at the start of every round
        for (int round = 0; round < 4; round++) begin
            do_reset();
            ready_pct = $urandom_range(40, 100);
            lat_min   = 1;
            lat_max   = $urandom_range(1, 4);
            d0 = dec_fires;
            for (int i = 0; i < 400; i++) begin
                bus.dec_ready       = ($urandom_range(0, 99) < 70);
                bus.redirect_valid  = (cyc_since_reset >= 1) && ($urandom_range(0, 99) < 4);
                bus.redirect_target = $urandom;
                tick();
            end
            bus.redirect_valid = 1'b0;
            check("t7_progress", 32'(dec_fires - d0 > 20), 1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
